// File: rtl/lsu_mem_port.sv
// Load/store initiator for the byte-addressed mem port: accepts one CPU request,
// runs an aligned access or a byte-by-byte split, and returns a registered response.
module lsu_mem_port #(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_out,
    input  logic [31:0] mem_data_in,
    output logic        mem_read_write,
    output logic [1:0]  mem_access_size,
    output logic        mem_unsigned
);
    typedef enum logic [1:0] {IDLE, ACCESS, SPLIT} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    state_t      state, state_nxt;
    logic        lat_write, lat_unsigned;
    logic [1:0]  lat_size, idx;
    logic [31:0] lat_addr, lat_wdata, asm_buf, asm_nxt, split_rdata;
    logic        accept, misaligned, reject, last_byte;

    assign req_ready  = (state == IDLE);
    assign accept     = req_valid && req_ready;
    assign misaligned = (req_size == SZ_HALF && req_address[0]) ||
                        (req_size == SZ_WORD && req_address[1:0] != 2'b00);
    assign reject     = (req_size == SZ_RSVD) || (misaligned && !SPLIT_MISALIGNED);
    assign last_byte  = (idx == ((lat_size == SZ_HALF) ? 2'd1 : 2'd3));

    // Assembly buffer including the byte arriving this cycle, so the last
    // split cycle can respond without an extra stage.
    always_comb begin
        asm_nxt = asm_buf;
        asm_nxt[{idx, 3'b000} +: 8] = mem_data_in[7:0];
        if (lat_size == SZ_HALF)
            split_rdata = {lat_unsigned ? 16'h0000 : {16{asm_nxt[15]}}, asm_nxt[15:0]};
        else
            split_rdata = asm_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !reject) state_nxt = misaligned ? SPLIT : ACCESS;
            ACCESS:  state_nxt = IDLE;
            SPLIT:   if (last_byte) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_address     = 32'h0;
        mem_data_out    = 32'h0;
        mem_read_write  = 1'b1;
        mem_access_size = SZ_WORD;
        mem_unsigned    = 1'b1;
        case (state)
            ACCESS: begin
                mem_address     = lat_addr;
                mem_data_out    = lat_wdata;
                mem_read_write  = ~lat_write;
                mem_access_size = lat_size;
                mem_unsigned    = lat_unsigned;
            end
            SPLIT: begin
                mem_address     = lat_addr + {30'h0, idx};
                mem_data_out    = {24'h0, lat_wdata[{idx, 3'b000} +: 8]};
                mem_read_write  = ~lat_write;
                mem_access_size = SZ_BYTE;
            end
            default: ;
        endcase
        // A store must never commit on a reset edge, whatever state we are in.
        if (reset) mem_read_write = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'h0;
            resp_error   <= 1'b0;
            lat_write    <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_addr     <= 32'h0;
            lat_wdata    <= 32'h0;
            idx          <= 2'd0;
            asm_buf      <= 32'h0;
        end else begin
            state      <= state_nxt;
            resp_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    lat_write    <= req_write;
                    lat_size     <= req_size;
                    lat_unsigned <= req_unsigned;
                    lat_addr     <= req_address;
                    lat_wdata    <= req_wdata;
                    idx          <= 2'd0;
                    asm_buf      <= 32'h0;
                    if (reject) begin
                        resp_valid <= 1'b1;
                        resp_error <= 1'b1;
                        resp_rdata <= 32'h0;
                    end
                end
                ACCESS: begin
                    resp_valid <= 1'b1;
                    resp_error <= 1'b0;
                    resp_rdata <= lat_write ? 32'h0 : mem_data_in;
                end
                SPLIT: begin
                    asm_buf <= asm_nxt;
                    idx     <= idx + 2'd1;
                    if (last_byte) begin
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        resp_rdata <= lat_write ? 32'h0 : split_rdata;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a 64-byte aliased memory model on the mem port.
module tb_lsu_mem_port;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_valid0 = 1'b0;
    logic        req_write = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic [31:0] req_address = 32'h0, req_wdata = 32'h0;
    logic        req_ready, resp_valid, resp_error, mem_read_write, mem_unsigned;
    logic [31:0] resp_rdata, mem_address, mem_data_out, mem_data_in;
    logic [1:0]  mem_access_size;
    logic        req_ready0, resp_valid0, resp_error0, mem_read_write0, mem_unsigned0;
    logic [31:0] resp_rdata0, mem_address0, mem_data_out0;
    logic [1:0]  mem_access_size0;

    logic [7:0]  mem [0:63];
    logic        mem_clr = 1'b1;
    int          wr_cnt = 0;
    int          n_chk = 0, n_err = 0;
    logic [5:0]  ma;
    logic [7:0]  b0, b1, b2, b3;

    always #5 clock = ~clock;

    lsu_mem_port #(.SPLIT_MISALIGNED(1'b1)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_address(req_address), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_error(resp_error), .mem_address(mem_address),
        .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
        .mem_read_write(mem_read_write), .mem_access_size(mem_access_size),
        .mem_unsigned(mem_unsigned));

    lsu_mem_port #(.SPLIT_MISALIGNED(1'b0)) dut0 (
        .clock(clock), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_address(req_address), .req_wdata(req_wdata), .resp_valid(resp_valid0),
        .resp_rdata(resp_rdata0), .resp_error(resp_error0), .mem_address(mem_address0),
        .mem_data_out(mem_data_out0), .mem_data_in(32'h0),
        .mem_read_write(mem_read_write0), .mem_access_size(mem_access_size0),
        .mem_unsigned(mem_unsigned0));

    // Memory model: combinational read with extension, write at posedge.
    always_comb begin
        ma = mem_address[5:0];
        b0 = mem[ma];
        b1 = mem[ma + 6'd1];
        b2 = mem[ma + 6'd2];
        b3 = mem[ma + 6'd3];
        case (mem_access_size)
            2'b00:   mem_data_in = mem_unsigned ? {24'h0, b0} : {{24{b0[7]}}, b0};
            2'b01:   mem_data_in = mem_unsigned ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
            default: mem_data_in = {b3, b2, b1, b0};
        endcase
    end

    always @(posedge clock) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
        end else if (!mem_read_write) begin
            wr_cnt <= wr_cnt + 1;
            mem[ma] <= mem_data_out[7:0];
            if (mem_access_size != 2'b00) mem[ma + 6'd1] <= mem_data_out[15:8];
            if (mem_access_size[1]) begin
                mem[ma + 6'd2] <= mem_data_out[23:16];
                mem[ma + 6'd3] <= mem_data_out[31:24];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        int lat;
        logic [31:0] rd;
        logic er;
        lat = 0;
        rd  = 32'hFFFF_FFFF;
        er  = 1'b0;
        @(negedge clock);
        chk({tag, "_rdy"}, {31'h0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_address = a; req_wdata = wd;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if (resp_valid) begin
                lat = i; rd = resp_rdata; er = resp_error;
                break;
            end
            @(negedge clock);
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"}, {31'h0, er}, {31'h0, exp_err});
    endtask

    initial begin
        int w0;
        logic seen;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_rv", {31'h0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", {31'h0, resp_error}, 32'd0);
        chk("rst_rdy", {31'h0, req_ready}, 32'd1);
        chk("rst_rw", {31'h0, mem_read_write}, 32'd1);
        chk("idle_addr", mem_address, 32'h0);
        chk("idle_size", {30'h0, mem_access_size}, 32'd2);
        chk("idle_uns", {31'h0, mem_unsigned}, 32'd1);
        chk("idle_dout", mem_data_out, 32'h0);
        reset = 1'b0;
        mem_clr = 1'b0;

        run("st_w", 1'b1, 2'b10, 1'b0, 32'h0100_0000, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
        chk("st_w_cnt", 32'(wr_cnt), 32'd1);
        run("ld_w", 1'b0, 2'b10, 1'b0, 32'h0100_0000, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
        run("st_b", 1'b1, 2'b00, 1'b0, 32'h0100_0000, 32'h0000_0080, 32'h0, 1'b0, 2);
        run("ld_bs", 1'b0, 2'b00, 1'b0, 32'h0100_0000, 32'h0, 32'hFFFF_FF80, 1'b0, 2);
        run("ld_bu", 1'b0, 2'b00, 1'b1, 32'h0100_0000, 32'h0, 32'h0000_0080, 1'b0, 2);

        run("sp_st", 1'b1, 2'b10, 1'b0, 32'h0100_0001, 32'h1122_3344, 32'h0, 1'b0, 5);
        chk("sp_cnt", 32'(wr_cnt), 32'd6);
        chk("sp_m1", {24'h0, mem[1]}, 32'h44);
        chk("sp_m2", {24'h0, mem[2]}, 32'h33);
        chk("sp_m3", {24'h0, mem[3]}, 32'h22);
        chk("sp_m4", {24'h0, mem[4]}, 32'h11);
        run("sp_ld", 1'b0, 2'b10, 1'b0, 32'h0100_0001, 32'h0, 32'h1122_3344, 1'b0, 5);

        run("st_b3", 1'b1, 2'b00, 1'b0, 32'h0100_0003, 32'h0000_0034, 32'h0, 1'b0, 2);
        run("st_b4", 1'b1, 2'b00, 1'b0, 32'h0100_0004, 32'h0000_00F2, 32'h0, 1'b0, 2);
        run("ld_hs", 1'b0, 2'b01, 1'b0, 32'h0100_0003, 32'h0, 32'hFFFF_F234, 1'b0, 3);
        run("ld_hu", 1'b0, 2'b01, 1'b1, 32'h0100_0003, 32'h0, 32'h0000_F234, 1'b0, 3);

        w0 = wr_cnt;
        run("rsv_ld", 1'b0, 2'b11, 1'b0, 32'h0100_0000, 32'h0, 32'h0, 1'b1, 1);
        run("rsv_st", 1'b1, 2'b11, 1'b0, 32'h0100_0000, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
        chk("rsv_nowr", 32'(wr_cnt), 32'(w0));

        run("wr_st", 1'b1, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0000_ABCD, 32'h0, 1'b0, 3);
        chk("wr_m63", {24'h0, mem[63]}, 32'hCD);
        chk("wr_m0", {24'h0, mem[0]}, 32'hAB);
        run("wr_ld", 1'b0, 2'b01, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0000_ABCD, 1'b0, 3);

        // Rejected misaligned half on the non-splitting instance.
        @(negedge clock);
        req_valid0 = 1'b1; req_write = 1'b0; req_size = 2'b01; req_unsigned = 1'b0;
        req_address = 32'h0100_0003;
        @(posedge clock);
        @(negedge clock);
        req_valid0 = 1'b0;
        chk("ns_rv", {31'h0, resp_valid0}, 32'd1);
        chk("ns_err", {31'h0, resp_error0}, 32'd1);
        chk("ns_rdata", resp_rdata0, 32'h0);
        chk("ns_addr", mem_address0, 32'h0);
        chk("ns_rdy", {31'h0, req_ready0}, 32'd1);

        // Reset in the second cycle of a split word store.
        w0 = wr_cnt;
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_address = 32'h0100_0009; req_wdata = 32'h5566_7788;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1 chk("mr_rw", {31'h0, mem_read_write}, 32'd1);
        @(negedge clock);
        chk("mr_rdy", {31'h0, req_ready}, 32'd1);
        reset = 1'b0;
        seen = resp_valid;
        repeat (5) begin
            @(negedge clock);
            seen = seen | resp_valid;
        end
        chk("mr_norsp", {31'h0, seen}, 32'd0);
        chk("mr_m9", {24'h0, mem[9]}, 32'h88);
        chk("mr_m10", {24'h0, mem[10]}, 32'h00);
        chk("mr_cnt", 32'(wr_cnt), 32'(w0 + 1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
